// File: rtl/modred_signed_pipe.sv
// ---------------------------------------------------------------------------
// modred_signed_pipe
//
// Purpose:
//     Elastic three-stage Barrett reducer. Takes a signed IN_W-bit operand and
//     returns its exact residue modulo the odd modulus Q. Each beat selects its
//     own result range: centered [-(Q-1)/2, (Q-1)/2] or non-negative [0, Q-1].
//     Valid/ready handshaking on both sides. Up to three beats can be held
//     while the consumer stalls.
//
// Ports:
//     clk          in   1      clock, all state updates on the rising edge
//     rst          in   1      synchronous active-high reset, drops all beats
//     in_valid     in   1      inZ / in_centered carry a beat
//     in_ready     out  1      pipe accepts a beat this cycle
//     inZ          in   IN_W   signed operand (two's complement)
//     in_centered  in   1      1: centered result, 0: non-negative result
//     out_valid    out  1      outZ holds a result
//     out_ready    in   1      consumer takes outZ this cycle
//     outZ         out  OUT_W  signed result, congruent to inZ mod Q
// ---------------------------------------------------------------------------
module modred_signed_pipe #(
    parameter int Q     = 120833,
    parameter int IN_W  = 33,
    parameter int OUT_W = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  inZ,
    input  logic                    in_centered,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] outZ
);

    localparam int QW = $clog2(Q);
    localparam int K  = IN_W + QW;
    // Width of the S2 remainder, which can reach just below 2Q.
    localparam int RW = QW + 1;
    localparam int PW = IN_W + K + 1;

    localparam logic [K:0]       ONE_K  = {1'b1, {K{1'b0}}};
    localparam logic [K:0]       Q_K    = (K+1)'(Q);
    localparam logic [K:0]       M      = ONE_K / Q_K;
    localparam logic [RW-1:0]    Q_R    = RW'(Q);
    localparam logic [RW-1:0]    HALF_R = RW'((Q - 1) / 2);
    localparam logic [OUT_W-1:0] Q_O    = OUT_W'(Q);

    // Elaboration-time parameter checks.
    generate
        if ((Q % 2) == 0 || Q < 3) begin : gBadModulus
            $error("modred_signed_pipe: Q must be an odd modulus >= 3");
        end
        if (Q >= (1 << (OUT_W - 1))) begin : gNarrowOutput
            $error("modred_signed_pipe: OUT_W too small for Q");
        end
    endgenerate

    logic              r_v1, r_v2, r_v3;
    logic [IN_W-1:0]   r_mag1;
    logic              r_sign1, r_mode1;
    logic [RW-1:0]     r_r2;
    logic              r_sign2, r_mode2;
    logic signed [OUT_W-1:0] r_outZ;

    logic              w_load1, w_load2, w_load3;
    logic [IN_W-1:0]   w_mag;
    logic [PW-1:0]     w_p;
    logic [IN_W:0]     w_qhat;
    logic [RW-1:0]     w_r;
    logic [RW-1:0]     w_rRed;
    logic [RW-1:0]     w_rNn;
    logic [OUT_W-1:0]  w_res;

    // A stage loads when it is empty or its content moves on this cycle.
    // The chain gives in_ready = !v1 | !v2 | !v3 | out_ready.
    assign w_load3   = !r_v3 | out_ready;
    assign w_load2   = !r_v2 | w_load3;
    assign w_load1   = !r_v1 | w_load2;
    assign in_ready  = w_load1;
    assign out_valid = r_v3;
    assign outZ      = r_outZ;

    // Two's complement magnitude. The most negative input maps to
    // 2^(IN_W-1), which still fits as an unsigned IN_W-bit value.
    assign w_mag = inZ[IN_W-1] ? (~inZ + 1'b1) : inZ;

    // Barrett estimate. qhat is at most one below the true quotient,
    // so the remainder falls in [0, 2Q).
    assign w_p    = PW'(r_mag1) * PW'(M);
    assign w_qhat = (IN_W+1)'(w_p >> K);
    assign w_r    = RW'(PW'(r_mag1) - PW'(w_qhat) * PW'(Q));

    // Final correction, sign fold and optional centering.
    assign w_rRed = (r_r2 >= Q_R) ? (r_r2 - Q_R) : r_r2;
    assign w_rNn  = (r_sign2 && (w_rRed != '0)) ? (Q_R - w_rRed) : w_rRed;
    assign w_res  = (r_mode2 && (w_rNn > HALF_R)) ? (OUT_W'(w_rNn) - Q_O)
                                                  : OUT_W'(w_rNn);

    // Stage 1: capture magnitude, sign and mode of an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_mag1  <= '0;
            r_sign1 <= 1'b0;
            r_mode1 <= 1'b0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_mag1  <= w_mag;
                r_sign1 <= inZ[IN_W-1];
                r_mode1 <= in_centered;
            end
        end
    end

    // Stage 2: hold the Barrett remainder in [0, 2Q).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_r2    <= '0;
            r_sign2 <= 1'b0;
            r_mode2 <= 1'b0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_r2    <= w_r;
                r_sign2 <= r_sign1;
                r_mode2 <= r_mode1;
            end
        end
    end

    // Stage 3: output register. The value is kept through bubbles and
    // stalls, so a held outZ never changes under a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_outZ <= '0;
        end else if (w_load3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_outZ <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_modred_signed_pipe.sv
// ---------------------------------------------------------------------------
// tb_modred_signed_pipe
//
// Purpose:
//     Self-checking bench for modred_signed_pipe. Drives a default instance
//     (Q=120833, IN_W=33) and a small instance (Q=3329, IN_W=24). Expected
//     residues come from plain modular arithmetic or from literal values.
//     Results are checked in order through per-instance queues.
// ---------------------------------------------------------------------------
module tb_modred_signed_pipe;

    localparam int Q1     = 120833;
    localparam int IN_W1  = 33;
    localparam int OUT_W1 = 18;
    localparam int Q2     = 3329;
    localparam int IN_W2  = 24;
    localparam int OUT_W2 = 13;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic                     in_valid1, in_ready1, in_cent1, out_valid1, out_ready1;
    logic signed [IN_W1-1:0]  inZ1;
    logic signed [OUT_W1-1:0] outZ1;

    logic                     in_valid2, in_ready2, in_cent2, out_valid2, out_ready2;
    logic signed [IN_W2-1:0]  inZ2;
    logic signed [OUT_W2-1:0] outZ2;

    exp_t   q1[$];
    longint q2[$];
    int     checks   = 0;
    int     failures = 0;
    int     cycleNo  = 0;
    bit     latCheck = 1'b0;
    bit     stall1   = 1'b0;
    bit     stall2   = 1'b0;
    logic   acc1;
    logic signed [OUT_W1-1:0] held1;
    logic signed [OUT_W2-1:0] held2;

    always #5 clk = ~clk;

    modred_signed_pipe #(.Q(Q1), .IN_W(IN_W1), .OUT_W(OUT_W1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .inZ         (inZ1),
        .in_centered (in_cent1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready1),
        .outZ        (outZ1)
    );

    modred_signed_pipe #(.Q(Q2), .IN_W(IN_W2), .OUT_W(OUT_W2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .inZ         (inZ2),
        .in_centered (in_cent2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .outZ        (outZ2)
    );

    // Canonical residue of z, then mapped into the centered range if asked.
    function automatic longint refMod(longint z, longint qm, bit centered);
        longint r;
        r = ((z % qm) + qm) % qm;
        if (centered && r > (qm - 1) / 2) r = r - qm;
        return r;
    endfunction

    task automatic checkOutput(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock cycle. Inputs are already driven (just after a falling edge).
    // Handshakes are sampled before the rising edge, then the cycle advances.
    task automatic applyStimulus(longint expVal1);
        exp_t e;
        longint e2;
        #1;
        if (stall1) begin
            checkOutput("stallValid1", out_valid1, 1);
            checkOutput("stallHold1", outZ1, held1);
        end
        if (stall2) begin
            checkOutput("stallHold2", outZ2, held2);
        end
        checkOutput("inReady1", in_ready1, (q1.size() < 3) || out_ready1);
        checkOutput("inReady2", in_ready2, (q2.size() < 3) || out_ready2);
        checkOutput("noStale1", out_valid1 && (q1.size() == 0), 0);
        checkOutput("noStale2", out_valid2 && (q2.size() == 0), 0);

        acc1 = in_valid1 && in_ready1;
        if (out_valid1 && out_ready1 && q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("value1", outZ1, e.val);
            if (latCheck) checkOutput("latency1", cycleNo - e.cyc, 3);
        end
        if (acc1) q1.push_back('{expVal1, cycleNo});

        if (out_valid2 && out_ready2 && q2.size() > 0) begin
            e2 = q2.pop_front();
            checkOutput("value2", outZ2, e2);
        end
        if (in_valid2 && in_ready2) q2.push_back(refMod(longint'(inZ2), Q2, in_cent2));

        stall1 = out_valid1 && !out_ready1;
        held1  = outZ1;
        stall2 = out_valid2 && !out_ready2;
        held2  = outZ2;
        @(posedge clk);
        @(negedge clk);
        cycleNo++;
    endtask

    // Reset with a competing beat on the input; reset must win.
    task automatic doReset();
        rst        = 1'b1;
        in_valid1  = 1'b1;
        inZ1       = 33'sd77;
        in_cent1   = 1'b1;
        in_valid2  = 1'b1;
        inZ2       = 24'sd5;
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstOutValid1", out_valid1, 0);
        checkOutput("rstOutZ1", outZ1, 0);
        checkOutput("rstInReady1", in_ready1, 1);
        checkOutput("rstOutValid2", out_valid2, 0);
        checkOutput("rstInReady2", in_ready2, 1);
        @(negedge clk);
        rst       = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        q1.delete();
        q2.delete();
        stall1 = 1'b0;
        stall2 = 1'b0;
    endtask

    task automatic sendBeat(logic signed [IN_W1-1:0] z, bit centered, longint expv);
        in_valid1 = 1'b1;
        inZ1      = z;
        in_cent1  = centered;
        applyStimulus(expv);
        checkOutput("accepted1", acc1, 1);
    endtask

    task automatic drain();
        in_valid1  = 1'b0;
        in_valid2  = 1'b0;
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) applyStimulus(0);
        checkOutput("drained1", q1.size(), 0);
        checkOutput("drained2", q2.size(), 0);
    endtask

    initial begin
        logic [63:0] rnd;
        int          sent;
        int          sel;
        bit          c;

        rst = 1'b1; in_valid1 = 1'b0; inZ1 = '0; in_cent1 = 1'b0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; inZ2 = '0; in_cent2 = 1'b0; out_ready2 = 1'b1;
        @(negedge clk);
        doReset();
        applyStimulus(0);

        // Centered defaults with exact three-cycle latency.
        latCheck = 1'b1;
        sendBeat(33'sd120833, 1'b1, 0);
        sendBeat(33'sd60416,  1'b1, 60416);
        sendBeat(33'sd60417,  1'b1, -60416);
        sendBeat(-33'sd1,     1'b1, -1);
        sendBeat(33'sd0,      1'b1, 0);
        drain();

        // Non-negative mode.
        sendBeat(-33'sd1,      1'b0, 120832);
        sendBeat(-33'sd120833, 1'b0, 0);
        sendBeat(33'sd60417,   1'b0, 60417);
        drain();

        // Extremes, mixing modes back to back.
        sendBeat({1'b1, 32'h0000_0000}, 1'b1, 41689);
        sendBeat({1'b1, 32'h0000_0000}, 1'b0, 41689);
        sendBeat({1'b0, 32'hFFFF_FFFF}, 1'b1, -41690);
        sendBeat({1'b0, 32'hFFFF_FFFF}, 1'b0, 79143);
        drain();
        latCheck = 1'b0;

        // Backpressure: ten incrementing beats, consumer stalls for cycles 4..9.
        sent = 0;
        for (int t = 0; t < 60 && (sent < 10 || q1.size() != 0); t++) begin
            out_ready1 = !(t >= 4 && t <= 9);
            in_valid1  = (sent < 10);
            inZ1       = IN_W1'(longint'(60410 + sent));
            in_cent1   = 1'b1;
            applyStimulus(refMod(longint'(60410 + sent), Q1, 1'b1));
            if (acc1) sent++;
        end
        checkOutput("bpAllSent", sent, 10);
        drain();

        // Reset with two beats in flight; nothing stale may follow.
        sendBeat(33'sd11, 1'b1, 11);
        sendBeat(33'sd12, 1'b1, 12);
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(0);

        // Random sweep on both instances with random handshakes and modes.
        for (int t = 0; t < 20000; t++) begin
            rnd = {$urandom(), $urandom()};
            sel = $urandom_range(0, 15);
            c   = 1'($urandom_range(0, 1));
            if (sel == 0)      inZ1 = {1'b1, 32'h0000_0000};
            else if (sel == 1) inZ1 = {1'b0, 32'hFFFF_FFFF};
            else if (sel == 2) inZ1 = IN_W1'(longint'($urandom_range(0, 2 * Q1)) - longint'(Q1));
            else               inZ1 = rnd[IN_W1-1:0];
            in_cent1   = c;
            in_valid1  = ($urandom_range(0, 3) != 0);
            out_ready1 = ($urandom_range(0, 3) != 0);
            inZ2       = rnd[63:64-IN_W2];
            in_cent2   = 1'($urandom_range(0, 1));
            in_valid2  = ($urandom_range(0, 3) != 0);
            out_ready2 = ($urandom_range(0, 2) != 0);
            applyStimulus(refMod(longint'(inZ1), Q1, c));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
